pixel_writer: RTL and testbench
===============================

Name: pixel_writer

Overview:
- Consumes 40-bit pixel commands from the pixel address generator and performs the memory access each one requires on a 16-bit-word graphics memory port.
- Access types: read-modify-write of a 1/2/4/8/16-bpp pixel, pixel read into a paste buffer, or a register-only update.
- Applies back-pressure to the generator through draw_busy.
- Maintains the transparent/ARGB register and two saturating collision counters.

Parameters:
- ADDR_W, 20, memory word address width (pixel_cmd[19:0]).
- COLL_W, 16, collision counter width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- pixel_cmd_rdy  in  1  pixel_cmd valid; accepted when high and draw_busy low.
- pixel_cmd  in  40  [39:36] cmd, [35:28] colour, [27:24] bpp-1, [23:20] pixel index, [19:0] address.
- draw_busy  out  1  registered; high while a memory operation is in flight.
- mem_addr  out  ADDR_W  word address; bit 0 forced 0.
- mem_rd_req  out  1  read request; held until mem_ack.
- mem_wr_req  out  1  write request; held until mem_ack.
- mem_wdata  out  16  write data.
- mem_rdata  in  16  read data; valid with mem_ack during a read.
- mem_ack  in  1  one-cycle completion pulse.
- argb  out  32  last SETARGB value; argb[7:0] is the transparent colour.
- wr_coll_cnt  out  COLL_W  PXWRI_M collision count.
- paste_coll_cnt  out  COLL_W  PXCOPY/PXPASTE_M collision count.

Behaviour:
- Reset values: all outputs 0, state IDLE, paste buffer 0.
- Commands: 1 PXWRI, 2 PXWRI_M, 3 PXPASTE, 4 PXPASTE_M, 6 PXCOPY, 7 SETARGB, 10 RST_PXWRI_M, 11 RST_PXPASTE_M. All other codes are accepted and ignored.
- Pixel geometry:
  - bpp = cmd[27:24]+1. Legal values are 1, 2, 4, 8, 16; any other value is treated as 16.
  - idx = cmd[23:20] & (16/bpp - 1).
  - Pixel 0 occupies the MSBs; field lsb = 16 - bpp*(idx+1).
  - Colour is truncated to bpp bits; for 16 bpp it is zero-extended.
- Register-only commands complete in IDLE on the accept edge; draw_busy is not raised:
  - SETARGB: argb <= cmd[31:0].
  - RST_PXWRI_M: clears wr_coll_cnt.
  - RST_PXPASTE_M: clears paste_coll_cnt.
- Memory commands, on the accept edge: latch cmd, set draw_busy, set mem_addr, and go to RD (or to WR for 16 bpp PXWRI/PXPASTE).
- FSM transitions:
  - IDLE -> RD on accept of a memory command.
  - RD: mem_rd_req high; on mem_ack, capture mem_rdata and go to MOD.
  - MOD, 1 cycle:
    - Extract the old pixel.
    - Merge the new pixel into the captured word.
    - Evaluate collision and transparency.
    - PXCOPY goes to DONE; all others go to WR, or to DONE when the write is suppressed.
  - WR: mem_wr_req high with mem_wdata; on mem_ack go to DONE.
  - DONE: drop draw_busy, return to IDLE.
- Acceptance timing: the next command is accepted no earlier than the cycle after DONE. Minimum memory-command throughput is 4 cycles plus memory latency.
- Per-command semantics:
  - PXWRI: write colour.
  - PXWRI_M: write colour; wr_coll_cnt increments if old pixel != argb[bpp-1:0].
  - PXCOPY: paste buffer <= old pixel; paste_coll_cnt increments if old pixel != cmd colour; no write.
  - PXPASTE: write the paste buffer.
  - PXPASTE_M: write is suppressed if paste buffer == argb[bpp-1:0]. Otherwise write, and increment paste_coll_cnt if old pixel != argb[bpp-1:0].
- Counters saturate at all-ones. A RST command on the same edge as an increment clears the counter; clear wins.
- mem_ack outside RD/WR is ignored.
- mem_rd_req and mem_wr_req are never high together.
- Address and data are stable while a request is high.
- Reset mid-operation: immediately returns to IDLE and drops requests. The in-flight command is lost.

Optional Feature:
- Macro: PIXEL_WRITER_WCACHE_EN.
- With the macro defined:
  - A one-word write cache holds the address and data of the last completed write.
  - A memory command whose address matches a valid entry skips RD: IDLE -> MOD, using the cached word.
  - The cache is updated on every WR completion.
  - The cache is invalidated by reset, SETARGB, RST_PXWRI_M and RST_PXPASTE_M.
- Without the macro: every non-16-bpp command performs RD; no cache logic is present.

Test Plan:
- Write 1 bpp pixel:
  - Stimulus: SETARGB 0x00000000, then PXWRI colour 0x01, bpp-1=0, idx=3, addr 0x00100; memory returns 0x0000.
  - Response: one read then one write of 0x1000 to 0x00100; draw_busy low after DONE.
- Masked write, 8 bpp, with collision:
  - Stimulus: argb 0x000000FF, PXWRI_M colour 0x3C, bpp-1=7, idx=1; memory returns 0xAB12.
  - Response: write 0xAB3C; wr_coll_cnt 0->1.
- Copy then masked paste, 4 bpp:
  - Stimulus: PXCOPY idx=2 on 0x1234 (pixel 0x3), colour field 0x0; then PXPASTE_M idx=0 on 0xF000, with argb[3:0]=0x0.
  - Response: no write for the copy; paste_coll_cnt=1 after the copy, 2 after the paste; paste writes 0x3000.
  - Repeat with paste buffer = argb[3:0]: no write is issued.
- 16 bpp direct write:
  - Stimulus: PXWRI colour 0x5A, bpp-1=15.
  - Response: no read; write 0x005A.
- Saturation and clear:
  - Stimulus: drive wr_coll_cnt to 0xFFFF, issue another collision, then RST_PXWRI_M coincident with an increment.
  - Response: count holds at 0xFFFF, then clears to 0.
- Reset mid-RD, and cache (macro defined):
  - Stimulus: assert reset while mem_rd_req is high.
  - Response: all outputs return to 0.
  - Stimulus: with the macro defined, two PXWRI commands to the same address back-to-back.
  - Response: the second command issues no mem_rd_req.

Source files
------------

// File: rtl/pixel_writer.sv
// Pixel writer: executes 40-bit pixel commands as read-modify-write, copy or
// paste accesses on a 16-bit memory port. Define PIXEL_WRITER_WCACHE_EN to add
// a one-word write cache that lets a command skip the read when it hits.
module pixel_writer #(
  parameter int ADDR_W = 20,
  parameter int COLL_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pixel_cmd_rdy,
  input  logic [39:0]       pixel_cmd,
  output logic              draw_busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_req,
  output logic              mem_wr_req,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [31:0]       argb,
  output logic [COLL_W-1:0] wr_coll_cnt,
  output logic [COLL_W-1:0] paste_coll_cnt,
  output logic [2:0]        dbg_state
);

  // Handshake: a command transfers on a rising edge where pixel_cmd_rdy is
  // high and draw_busy is low. A memory request (rd or wr) stays high with
  // stable address/data until the cycle mem_ack is sampled high; acks seen
  // while no request is pending are ignored.

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_MOD  = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [3:0] C_PXWRI     = 4'd1;
  localparam logic [3:0] C_PXWRI_M   = 4'd2;
  localparam logic [3:0] C_PXPASTE   = 4'd3;
  localparam logic [3:0] C_PXPASTE_M = 4'd4;
  localparam logic [3:0] C_PXCOPY    = 4'd6;
  localparam logic [3:0] C_SETARGB   = 4'd7;
  localparam logic [3:0] C_RST_WR    = 4'd10;
  localparam logic [3:0] C_RST_PASTE = 4'd11;

  logic [2:0]        state_q, state_d;
  logic [3:0]        code_q, code_d;
  logic [7:0]        colour_q, colour_d;
  logic [2:0]        bsel_q, bsel_d;
  logic [3:0]        lsb_q, lsb_d;
  logic [15:0]       rdata_q, rdata_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [31:0]       argb_q, argb_d;
  logic [COLL_W-1:0] wcnt_q, wcnt_d;
  logic [COLL_W-1:0] pcnt_q, pcnt_d;
  logic [15:0]       paste_q, paste_d;

  logic [3:0]        in_code;
  logic [ADDR_W-1:0] cmd_addr;
  logic [2:0]        in_bsel;
  logic [3:0]        in_lsb;
  logic              accept;
  logic              is_reg_cmd;
  logic              is_mem_cmd;
  logic              cache_hit;
  logic [15:0]       cache_word;

  assign in_code    = pixel_cmd[39:36];
  assign cmd_addr   = ADDR_W'(pixel_cmd[19:0] & 20'hFFFFE);
  assign accept     = pixel_cmd_rdy && !busy_q && (state_q == S_IDLE);
  assign is_reg_cmd = (in_code == C_SETARGB) || (in_code == C_RST_WR) ||
                      (in_code == C_RST_PASTE);
  assign is_mem_cmd = (in_code == C_PXWRI) || (in_code == C_PXWRI_M) ||
                      (in_code == C_PXPASTE) || (in_code == C_PXPASTE_M) ||
                      (in_code == C_PXCOPY);

  // Pixel width as a 3-bit select (0:1 1:2 2:4 3:8 4:16 bpp); pixel 0 is the MSB field.
  always_comb begin
    in_bsel = 3'd4;
    in_lsb  = 4'd0;
    case (pixel_cmd[27:24])
      4'd0: begin in_bsel = 3'd0; in_lsb = 4'd15 - pixel_cmd[23:20]; end
      4'd1: begin in_bsel = 3'd1; in_lsb = 4'd14 - {pixel_cmd[22:20], 1'b0}; end
      4'd3: begin in_bsel = 3'd2; in_lsb = 4'd12 - {pixel_cmd[21:20], 2'b00}; end
      4'd7: begin in_bsel = 3'd3; in_lsb = 4'd8 - {pixel_cmd[20], 3'b000}; end
      default: begin in_bsel = 3'd4; in_lsb = 4'd0; end
    endcase
  end

  logic [15:0] fmask;
  logic [15:0] old_pix;
  logic [15:0] tcol;
  logic [15:0] col_t;
  logic [15:0] paste_t;
  logic [15:0] new_pix;
  logic [15:0] merged;

  always_comb begin
    case (bsel_q)
      3'd0:    fmask = 16'h0001;
      3'd1:    fmask = 16'h0003;
      3'd2:    fmask = 16'h000F;
      3'd3:    fmask = 16'h00FF;
      default: fmask = 16'hFFFF;
    endcase
  end

  assign old_pix = (rdata_q >> lsb_q) & fmask;
  assign tcol    = argb_q[15:0] & fmask;
  assign col_t   = {8'h00, colour_q} & fmask;
  assign paste_t = paste_q & fmask;
  assign new_pix = ((code_q == C_PXWRI) || (code_q == C_PXWRI_M)) ? col_t : paste_t;
  assign merged  = (rdata_q & ~(fmask << lsb_q)) | (new_pix << lsb_q);

  logic wr_inc, pa_inc, wr_clr, pa_clr;

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    colour_d = colour_q;
    bsel_d   = bsel_q;
    lsb_d    = lsb_q;
    rdata_d  = rdata_q;
    busy_d   = busy_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    argb_d   = argb_q;
    paste_d  = paste_q;
    wr_inc   = 1'b0;
    pa_inc   = 1'b0;
    wr_clr   = 1'b0;
    pa_clr   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (in_code == C_SETARGB) argb_d = pixel_cmd[31:0];
          if (in_code == C_RST_WR) wr_clr = 1'b1;
          if (in_code == C_RST_PASTE) pa_clr = 1'b1;
          if (is_mem_cmd) begin
            code_d   = in_code;
            colour_d = pixel_cmd[35:28];
            bsel_d   = in_bsel;
            lsb_d    = in_lsb;
            busy_d   = 1'b1;
            addr_d   = cmd_addr;
            // Full-word plain writes need no old data.
            if ((in_bsel == 3'd4) && ((in_code == C_PXWRI) || (in_code == C_PXPASTE))) begin
              state_d = S_WR;
              wdata_d = (in_code == C_PXWRI) ? {8'h00, pixel_cmd[35:28]} : paste_q;
            end else if (cache_hit) begin
              state_d = S_MOD;
              rdata_d = cache_word;
            end else begin
              state_d = S_RD;
            end
          end
        end
      end
      S_RD: begin
        if (mem_ack) begin
          rdata_d = mem_rdata;
          state_d = S_MOD;
        end
      end
      S_MOD: begin
        case (code_q)
          C_PXCOPY: begin
            paste_d = old_pix;
            pa_inc  = (old_pix != col_t);
            state_d = S_DONE;
          end
          C_PXPASTE_M: begin
            if (paste_t == tcol) begin
              state_d = S_DONE;
            end else begin
              pa_inc  = (old_pix != tcol);
              wdata_d = merged;
              state_d = S_WR;
            end
          end
          C_PXWRI_M: begin
            wr_inc  = (old_pix != tcol);
            wdata_d = merged;
            state_d = S_WR;
          end
          default: begin
            wdata_d = merged;
            state_d = S_WR;
          end
        endcase
      end
      S_WR: begin
        if (mem_ack) state_d = S_DONE;
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Saturating counters; a clear on the same edge as an increment wins.
    if (wr_clr) wcnt_d = '0;
    else if (wr_inc && (wcnt_q != '1)) wcnt_d = wcnt_q + 1'b1;
    else wcnt_d = wcnt_q;
    if (pa_clr) pcnt_d = '0;
    else if (pa_inc && (pcnt_q != '1)) pcnt_d = pcnt_q + 1'b1;
    else pcnt_d = pcnt_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      code_q   <= '0;
      colour_q <= '0;
      bsel_q   <= '0;
      lsb_q    <= '0;
      rdata_q  <= '0;
      busy_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      argb_q   <= '0;
      wcnt_q   <= '0;
      pcnt_q   <= '0;
      paste_q  <= '0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      colour_q <= colour_d;
      bsel_q   <= bsel_d;
      lsb_q    <= lsb_d;
      rdata_q  <= rdata_d;
      busy_q   <= busy_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      argb_q   <= argb_d;
      wcnt_q   <= wcnt_d;
      pcnt_q   <= pcnt_d;
      paste_q  <= paste_d;
    end
  end

`ifdef PIXEL_WRITER_WCACHE_EN
  logic              cache_v_q, cache_v_d;
  logic [ADDR_W-1:0] cache_a_q, cache_a_d;
  logic [15:0]       cache_w_q, cache_w_d;

  assign cache_hit  = cache_v_q && (cache_a_q == cmd_addr);
  assign cache_word = cache_w_q;

  always_comb begin
    cache_v_d = cache_v_q;
    cache_a_d = cache_a_q;
    cache_w_d = cache_w_q;
    if ((state_q == S_WR) && mem_ack) begin
      cache_v_d = 1'b1;
      cache_a_d = addr_q;
      cache_w_d = wdata_q;
    end else if (accept && is_reg_cmd) begin
      cache_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cache_v_q <= 1'b0;
      cache_a_q <= '0;
      cache_w_q <= '0;
    end else begin
      cache_v_q <= cache_v_d;
      cache_a_q <= cache_a_d;
      cache_w_q <= cache_w_d;
    end
  end
`else
  assign cache_hit  = 1'b0 & is_reg_cmd;
  assign cache_word = 16'h0000;
`endif

  assign draw_busy      = busy_q;
  assign mem_addr       = addr_q;
  assign mem_rd_req     = (state_q == S_RD);
  assign mem_wr_req     = (state_q == S_WR);
  assign mem_wdata      = wdata_q;
  assign argb           = argb_q;
  assign wr_coll_cnt    = wcnt_q;
  assign paste_coll_cnt = pcnt_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_pixel_writer.sv
// Bench for pixel_writer: directed scenarios plus random commands, with a
// memory responder, a word-level reference model and an access scoreboard.
module tb_pixel_writer;

  localparam int ADDR_W = 20;
  localparam int COLL_W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              pixel_cmd_rdy;
  logic [39:0]       pixel_cmd;
  logic              draw_busy;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_req;
  logic              mem_wr_req;
  logic [15:0]       mem_wdata;
  logic [15:0]       mem_rdata;
  logic              mem_ack;
  logic [31:0]       argb;
  logic [COLL_W-1:0] wr_coll_cnt;
  logic [COLL_W-1:0] paste_coll_cnt;
  logic [2:0]        dbg_state;

  pixel_writer #(.ADDR_W(ADDR_W), .COLL_W(COLL_W)) dut (
    .clk(clk), .reset(reset),
    .pixel_cmd_rdy(pixel_cmd_rdy), .pixel_cmd(pixel_cmd),
    .draw_busy(draw_busy), .mem_addr(mem_addr),
    .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .argb(argb), .wr_coll_cnt(wr_coll_cnt), .paste_coll_cnt(paste_coll_cnt),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [36:0] exp_q[$];   // {is_write, addr[19:0], wdata[15:0]}
  int          n_checks = 0;
  int          n_fail = 0;
  int          rd_seen = 0;
  bit          hold_ack = 1'b0;
  logic [15:0] sim_mem[int];
  logic [15:0] ref_mem[int];

  // reference model state
  int  m_argb, m_wcnt, m_pcnt, m_paste;
  bit  m_cv;
  int  m_ca;
  localparam int CMAX = (1 << COLL_W) - 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic end_test();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  function automatic int mem_get(input int a);
    if (ref_mem.exists(a)) return int'(ref_mem[a]);
    return 0;
  endfunction

  function automatic logic [39:0] mk(input int code, input int col, input int bm1,
                                     input int idx, input int addr);
    logic [39:0] c;
    c = {code[3:0], col[7:0], bm1[3:0], idx[3:0], addr[19:0]};
    return c;
  endfunction

  task automatic model_reset();
    m_argb = 0; m_wcnt = 0; m_pcnt = 0; m_paste = 0; m_cv = 1'b0; m_ca = 0;
  endtask

  // Word-level model of one command; pushes the memory accesses it expects.
  task automatic model_cmd(input logic [39:0] c, output bit is_mem);
    int code, col, bpp, idx, lsb, fmask, addr, word, old, tcol, newpix, nw;
    bit do_wr, hit;
    code  = int'(c[39:36]);
    col   = int'(c[35:28]);
    bpp   = int'(c[27:24]) + 1;
    if (!(bpp inside {1, 2, 4, 8})) bpp = 16;
    idx   = int'(c[23:20]) % (16 / bpp);
    lsb   = 16 - bpp * (idx + 1);
    fmask = (1 << bpp) - 1;
    addr  = int'(c[19:0]) & 32'hFFFFE;
    is_mem = 1'b0;
    case (code)
      7:  begin m_argb = int'(c[31:0]); m_cv = 1'b0; end
      10: begin m_wcnt = 0; m_cv = 1'b0; end
      11: begin m_pcnt = 0; m_cv = 1'b0; end
      1, 2, 3, 4, 6: begin
        is_mem = 1'b1;
        word = mem_get(addr);
        hit = 1'b0;
`ifdef PIXEL_WRITER_WCACHE_EN
        hit = m_cv && (m_ca == addr);
`endif
        if (!(bpp == 16 && (code == 1 || code == 3)) && !hit)
          exp_q.push_back({1'b0, addr[19:0], 16'h0000});
        old    = (word >> lsb) & fmask;
        tcol   = m_argb & fmask;
        newpix = (code <= 2) ? (col & fmask) : (m_paste & fmask);
        do_wr  = 1'b1;
        if (code == 2 && old != tcol && m_wcnt < CMAX) m_wcnt++;
        if (code == 6) begin
          do_wr = 1'b0;
          if (old != (col & fmask) && m_pcnt < CMAX) m_pcnt++;
          m_paste = old;
        end
        if (code == 4) begin
          if ((m_paste & fmask) == tcol) do_wr = 1'b0;
          else if (old != tcol && m_pcnt < CMAX) m_pcnt++;
        end
        if (do_wr) begin
          nw = (word & ~(fmask << lsb) & 32'hFFFF) | (newpix << lsb);
          exp_q.push_back({1'b1, addr[19:0], nw[15:0]});
          ref_mem[addr] = nw[15:0];
          m_cv = 1'b1;
          m_ca = addr;
        end
      end
      default: ;
    endcase
  endtask

  // ---------------- memory responder ----------------
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    mem_ack = 1'b0;
    mem_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      if (reset) begin
        mem_ack = 1'b0;
      end else if (mem_rd_req || mem_wr_req) begin
        if (hold_ack) begin
          mem_ack = 1'b0;
        end else if (wait_cnt == 0) begin
          mem_ack = 1'b1;
          if (mem_rd_req) begin
            mem_rdata = sim_mem.exists(int'(mem_addr)) ? sim_mem[int'(mem_addr)] : 16'h0000;
          end else begin
            mem_rdata = 16'($urandom);
            sim_mem[int'(mem_addr)] = mem_wdata;
          end
          wait_cnt = $urandom_range(0, 3);
        end else begin
          mem_ack = 1'b0;
          mem_rdata = 16'($urandom);
          wait_cnt--;
        end
      end else begin
        // stray acks while nothing is requested must be ignored
        mem_ack = ($urandom_range(0, 7) == 0);
        mem_rdata = 16'($urandom);
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [36:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (!reset && mem_ack && (mem_rd_req || mem_wr_req)) begin
        check("req_exclusive", {31'd0, mem_rd_req & mem_wr_req}, 32'd0);
        if (mem_rd_req) rd_seen++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_access: got wr=%0b addr %h data %h expected none",
                   mem_wr_req, mem_addr, mem_wdata);
        end else begin
          e = exp_q.pop_front();
          check("acc_kind", {31'd0, mem_wr_req}, {31'd0, e[36]});
          check("acc_addr", {12'd0, mem_addr}, {12'd0, e[35:16]});
          if (e[36]) check("acc_wdata", {16'd0, mem_wdata}, {16'd0, e[15:0]});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic preload(input int a, input logic [15:0] d);
    sim_mem[a] = d;
    ref_mem[a] = d;
  endtask

  task automatic issue(input logic [39:0] c);
    bit is_mem;
    int n;
    model_cmd(c, is_mem);
    pixel_cmd = c;
    pixel_cmd_rdy = 1'b1;
    @(posedge clk);
    #1;
    pixel_cmd_rdy = 1'b0;
    pixel_cmd = {$urandom, 8'($urandom)};
    check("busy_after_accept", {31'd0, draw_busy}, {31'd0, is_mem});
    n = 0;
    while (draw_busy && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (draw_busy) begin
      n_checks++;
      n_fail++;
      $display("FAIL cmd_timeout: got draw_busy 1 expected 0 within 300 cycles");
      end_test();
    end
    check("pending_accesses", exp_q.size(), 0);
    check("argb", argb, m_argb);
    check("wr_coll_cnt", {28'd0, wr_coll_cnt}, m_wcnt);
    check("paste_coll_cnt", {28'd0, paste_coll_cnt}, m_pcnt);
    repeat ($urandom_range(0, 2)) @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, {31'd0, draw_busy}, 0);
    check({tag, "_addr"}, {12'd0, mem_addr}, 0);
    check({tag, "_rd_req"}, {31'd0, mem_rd_req}, 0);
    check({tag, "_wr_req"}, {31'd0, mem_wr_req}, 0);
    check({tag, "_wdata"}, {16'd0, mem_wdata}, 0);
    check({tag, "_argb"}, argb, 0);
    check({tag, "_wcnt"}, {28'd0, wr_coll_cnt}, 0);
    check({tag, "_pcnt"}, {28'd0, paste_coll_cnt}, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, rd0, code, col, a;
    logic [31:0] r;
    pixel_cmd_rdy = 1'b0;
    pixel_cmd = '0;
    reset = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // 1 bpp write, pixel 3 -> bit 12
    issue(mk(7, 0, 0, 0, 0));
    issue(mk(1, 8'h01, 0, 3, 20'h00100));
    check("t1_word", {16'd0, sim_mem[32'h100]}, 32'h1000);

    // 8 bpp masked write with collision
    issue(mk(7, 0, 0, 0, 0) | 40'h00000000FF);
    preload(32'h200, 16'hAB12);
    issue(mk(2, 8'h3C, 7, 1, 20'h00200));
    check("t2_word", {16'd0, sim_mem[32'h200]}, 32'hAB3C);
    check("t2_wcnt", {28'd0, wr_coll_cnt}, 1);

    // 4 bpp copy then masked paste
    issue(mk(7, 0, 0, 0, 0));
    preload(32'h300, 16'h1234);
    issue(mk(6, 0, 3, 2, 20'h00300));
    check("t3_pcnt_copy", {28'd0, paste_coll_cnt}, 1);
    preload(32'h400, 16'hF000);
    issue(mk(4, 0, 3, 0, 20'h00400));
    check("t3_word", {16'd0, sim_mem[32'h400]}, 32'h3000);
    check("t3_pcnt_paste", {28'd0, paste_coll_cnt}, 2);
    issue(mk(7, 0, 0, 0, 0) | 40'h0000000003);
    preload(32'h500, 16'hF000);
    issue(mk(4, 0, 3, 0, 20'h00500));
    check("t3_suppressed", {16'd0, sim_mem[32'h500]}, 32'hF000);

    // 16 bpp direct write, no read
    rd0 = rd_seen;
    issue(mk(1, 8'h5A, 15, 0, 20'h00600));
    check("t4_word", {16'd0, sim_mem[32'h600]}, 32'h005A);
    check("t4_no_read", rd_seen - rd0, 0);

    // saturation then clear
    issue(mk(7, 0, 0, 0, 0));
    for (int i = 0; i < 20; i++) issue(mk(2, 8'h01, 0, 0, 20'h00700));
    check("t5_saturated", {28'd0, wr_coll_cnt}, CMAX);
    issue(mk(10, 0, 0, 0, 0));
    check("t5_cleared", {28'd0, wr_coll_cnt}, 0);

    // back-to-back writes to one address
    rd0 = rd_seen;
    issue(mk(1, 8'h11, 7, 0, 20'h00800));
    issue(mk(1, 8'h22, 7, 1, 20'h00801));
`ifdef PIXEL_WRITER_WCACHE_EN
    check("t6_reads", rd_seen - rd0, 1);
`else
    check("t6_reads", rd_seen - rd0, 2);
`endif

    // random traffic
    for (int i = 0; i < 400; i++) begin
      code = $urandom_range(0, 15);
      col = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : $urandom_range(0, 255);
      a = 32'h01000 + $urandom_range(0, 15);
      if (code == 7) begin
        r = $urandom;
        if ($urandom_range(0, 1) == 1) r[15:0] = 16'($urandom_range(0, 3));
        issue({4'd7, 4'd0, r});
      end else begin
        issue(mk(code, col, $urandom_range(0, 15), $urandom_range(0, 15), a));
      end
    end

    // reset while a read is pending
    hold_ack = 1'b1;
    pixel_cmd = mk(1, 8'h01, 0, 5, 20'h02000);
    pixel_cmd_rdy = 1'b1;
    @(posedge clk);
    #1;
    pixel_cmd_rdy = 1'b0;
    n = 0;
    while (!mem_rd_req && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("t7_rd_pending", {31'd0, mem_rd_req}, 1);
    #3;
    reset = 1'b1;
    #1;
    check_all_zero("midrd");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    hold_ack = 1'b0;
    exp_q.delete();
    model_reset();
    @(posedge clk);
    #1;
    issue(mk(1, 8'h01, 0, 0, 20'h02002));
    check("t7_after_reset", {16'd0, sim_mem[32'h2002]}, 32'h8000);

    end_test();
  end

endmodule
